comms_bus_arbiter: RTL and testbench

COMMS_BUS_ARBITER -- requirements
Module: comms_bus_arbiter

---
 rtl/comms_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_comms_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comms_bus_arbiter.sv
// -----------------------------------------------------------------------------
// comms_bus_arbiter
//
// Shares a single core bus between two requesters: the SPI instruction handler
// (requester 0) and the local sequencer (requester 1). The block serves one
// transaction at a time. Simultaneous requests are granted round-robin. Each
// granted transaction runs IDLE -> ISSUE -> (WAIT for reads) -> DONE.
//
// Parameters
//   READ_LATENCY      cycles from READ issue to valid core read data (1..15)
//
// Ports
//   clk               single clock, rising edge
//   rst_n             asynchronous active-low reset
//   req_i[1:0]        per-requester transaction request
//   instr0_i/instr1_i requested instruction code
//   addr0_i/addr1_i   requested core address
//   val0_i/val1_i     write value
//   ack_o[1:0]        one-cycle completion pulse to the served requester
//   rdata_o           read result, valid from the ack cycle of a READ onwards
//   busy_o            high whenever a transaction is in flight
//   bus_instruction_o shared core bus instruction (NOP outside ISSUE)
//   bus_address_o     shared core bus address
//   bus_value_o       shared core bus write value
//   bus_value_i       output value returned by the core interfaces
// -----------------------------------------------------------------------------
module comms_bus_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    input  logic [7:0]  instr0_i,
    input  logic [7:0]  instr1_i,
    input  logic [23:0] addr0_i,
    input  logic [23:0] addr1_i,
    input  logic [31:0] val0_i,
    input  logic [31:0] val1_i,
    output logic [1:0]  ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic [7:0]  bus_instruction_o,
    output logic [23:0] bus_address_o,
    output logic [31:0] bus_value_o,
    input  logic [31:0] bus_value_i
);

    localparam logic [7:0] INSTR_NOP  = 8'h00;
    localparam logic [7:0] INSTR_READ = 8'h01;
    localparam logic [3:0] LAT_M1     = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_gnt;      // index of the requester owning the current transaction
    logic        r_last;     // index of the requester served most recently
    logic [7:0]  r_instr;
    logic [23:0] r_addr;
    logic [31:0] r_val;
    logic [31:0] r_rdata;
    logic [3:0]  r_cnt;

    logic        w_grant;
    logic        w_start;
    logic        w_is_read;

    // A lone request always wins; on a tie the requester not served last wins.
    always_comb begin
        w_grant = req_i[1];
        if (req_i == 2'b11) begin
            w_grant = ~r_last;
        end
    end

    assign w_start   = (r_state == ST_IDLE) && (req_i != 2'b00);
    assign w_is_read = (r_instr == INSTR_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        ack_o             = 2'b00;
        busy_o            = 1'b1;
        bus_instruction_o = INSTR_NOP;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (req_i != 2'b00) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus_instruction_o = r_instr;
                w_next            = w_is_read ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_o  = r_gnt ? 2'b10 : 2'b01;
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request fields are captured only at grant, so requesters may change
    // their inputs freely while the transaction is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_instr <= 8'h00;
            r_addr  <= 24'h000000;
            r_val   <= 32'h00000000;
            r_rdata <= 32'h00000000;
            r_cnt   <= 4'd0;
        end else begin
            if (w_start) begin
                r_gnt   <= w_grant;
                r_instr <= w_grant ? instr1_i : instr0_i;
                r_addr  <= w_grant ? addr1_i  : addr0_i;
                r_val   <= w_grant ? val1_i   : val0_i;
            end
            // The counter runs READ_LATENCY-1 down to 0, one step per WAIT cycle;
            // the core data is valid on the cycle the count reaches 0.
            if (r_state == ST_ISSUE && w_is_read) begin
                r_cnt <= LAT_M1;
            end else if (r_state == ST_WAIT) begin
                if (r_cnt == 4'd0) begin
                    r_rdata <= bus_value_i;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            if (r_state == ST_DONE) begin
                r_last <= r_gnt;
            end
        end
    end

    assign bus_address_o = r_addr;
    assign bus_value_o   = r_val;
    assign rdata_o       = r_rdata;

endmodule

// File: tb/tb_comms_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_comms_bus_arbiter
//
// Scoreboard bench for comms_bus_arbiter. The driver applies directed and
// random requests. A transaction-level model schedules every grant: its cycle,
// its ack cycle, and the read data taken from the per-cycle core return values.
// The model fills per-cycle expectation tables and pushes each expected ack
// into a queue. A negedge monitor compares the DUT against both.
// -----------------------------------------------------------------------------
module tb_comms_bus_arbiter;

    localparam int L    = 2;
    localparam int NCYC = 4096;

    localparam logic [7:0] C_READ     = 8'h01;
    localparam logic [7:0] C_WRITE    = 8'h02;
    localparam logic [7:0] C_TRANSFER = 8'h03;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  instr0, instr1;
    logic [23:0] addr0, addr1;
    logic [31:0] val0, val1;
    logic [31:0] bus_value_i;
    logic [1:0]  ack_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic [7:0]  bus_instruction_o;
    logic [23:0] bus_address_o;
    logic [31:0] bus_value_o;

    comms_bus_arbiter #(.READ_LATENCY(L)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_i             (req),
        .instr0_i          (instr0),
        .instr1_i          (instr1),
        .addr0_i           (addr0),
        .addr1_i           (addr1),
        .val0_i            (val0),
        .val1_i            (val1),
        .ack_o             (ack_o),
        .rdata_o           (rdata_o),
        .busy_o            (busy_o),
        .bus_instruction_o (bus_instruction_o),
        .bus_address_o     (bus_address_o),
        .bus_value_o       (bus_value_o),
        .bus_value_i       (bus_value_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  ack;
        bit          rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;

    logic [31:0] bv        [NCYC];
    bit          exp_busy  [NCYC];
    logic [7:0]  exp_instr [NCYC];
    logic [1:0]  exp_ack   [NCYC];
    bit          exp_av    [NCYC];
    logic [23:0] exp_addr  [NCYC];
    logic [31:0] exp_val   [NCYC];
    logic [31:0] exp_rdata [NCYC];

    int cyc         = 0;
    int next_free   = 0;
    int last_served = 1;
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int c);
        sbq.delete();
        for (int k = c; k < NCYC; k++) begin
            exp_busy[k]  = 1'b0;
            exp_instr[k] = 8'h00;
            exp_ack[k]   = 2'b00;
            exp_av[k]    = 1'b0;
            exp_addr[k]  = 24'h0;
            exp_val[k]   = 32'h0;
            exp_rdata[k] = 32'h0;
        end
        last_served = 1;
        next_free   = 0;
    endtask

    // One grant decision per cycle, taken from the inputs driven this cycle.
    task automatic model_step();
        int          g;
        int          a;
        bit          rd;
        logic [7:0]  in;
        logic [23:0] ad;
        logic [31:0] vl;
        exp_t        e;
        if (rst_n && cyc >= next_free && req != 2'b00) begin
            if (req == 2'b11) g = (last_served == 1) ? 0 : 1;
            else              g = (req == 2'b10) ? 1 : 0;
            in = (g == 1) ? instr1 : instr0;
            ad = (g == 1) ? addr1  : addr0;
            vl = (g == 1) ? val1   : val0;
            rd = (in == C_READ);
            a  = cyc + 2 + (rd ? L : 0);
            for (int k = cyc + 1; k <= a; k++) begin
                exp_busy[k] = 1'b1;
                exp_av[k]   = 1'b1;
                exp_addr[k] = ad;
                exp_val[k]  = vl;
            end
            exp_instr[cyc + 1] = in;
            exp_ack[a]         = (g == 1) ? 2'b10 : 2'b01;
            if (rd) begin
                for (int k = a; k < NCYC; k++) exp_rdata[k] = bv[a - 1];
            end
            e.cyc   = a;
            e.ack   = exp_ack[a];
            e.rd    = rd;
            e.rdata = bv[a - 1];
            sbq.push_back(e);
            last_served = g;
            next_free   = a + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        bus_value_i = bv[cyc];
    endtask

    task automatic drain();
        int guard = 0;
        while (cyc < next_free && guard < 100) begin
            tick();
            req = 2'b00;
            model_step();
            guard++;
        end
    endtask

    // Asserts reset mid-cycle for n cycles, then releases it mid-cycle so the
    // current req is arbitrated on the following edge.
    task automatic do_reset(input int n);
        tick();
        rst_n = 1'b0;
        model_reset(cyc);
        #1;
        chk("rst_addr", 32'(bus_address_o), 32'h0);
        chk("rst_val", bus_value_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        for (int k = 1; k < n; k++) begin
            tick();
            model_step();
        end
        tick();
        rst_n = 1'b1;
        model_step();
    endtask

    function automatic logic [7:0] rand_instr();
        case ($urandom_range(0, 3))
            0:       return C_READ;
            1:       return C_WRITE;
            2:       return C_TRANSFER;
            default: return 8'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (cyc > 0 && cyc < NCYC) begin
            chk("busy", 32'(busy_o), 32'(exp_busy[cyc]));
            chk("bus_instr", 32'(bus_instruction_o), 32'(exp_instr[cyc]));
            chk("ack_cycle", 32'(ack_o), 32'(exp_ack[cyc]));
            chk("rdata_hold", rdata_o, exp_rdata[cyc]);
            if (exp_av[cyc]) begin
                chk("bus_addr", 32'(bus_address_o), 32'(exp_addr[cyc]));
                chk("bus_val", bus_value_o, exp_val[cyc]);
            end
            if (ack_o != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("sb_spurious_ack", 32'(ack_o), 32'h0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_ack_id", 32'(ack_o), 32'(mon_e.ack));
                    chk("sb_ack_time", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.rd) chk("sb_rdata", rdata_o, mon_e.rdata);
                end
            end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                mon_e = sbq.pop_front();
                chk("sb_missing_ack", 32'(ack_o), 32'(mon_e.ack));
            end
        end
    end

    initial begin
        int rst_hold;
        rst_n = 1'b0;
        req = 2'b00;
        instr0 = 8'h0; instr1 = 8'h0;
        addr0 = 24'h0; addr1 = 24'h0;
        val0 = 32'h0; val1 = 32'h0;
        for (int k = 0; k < NCYC; k++) bv[k] = $urandom;
        bus_value_i = bv[0];
        model_reset(0);

        // power-on reset
        repeat (3) begin tick(); model_step(); end
        tick(); rst_n = 1'b1; model_step();

        // single WRITE from requester 0
        tick(); req = 2'b01; instr0 = C_WRITE; addr0 = 24'h000000; val0 = 32'h1; model_step();
        drain();

        // READ from requester 1 with core returning 3
        for (int k = cyc + 1; k < cyc + 12; k++) bv[k] = 32'h3;
        tick(); req = 2'b10; instr1 = C_READ; addr1 = 24'h000002; val1 = 32'h0; model_step();
        drain();

        // both request right after reset, held so grants alternate
        req = 2'b00;
        do_reset(2);
        tick(); req = 2'b11;
        instr0 = C_WRITE; addr0 = 24'h00000A; val0 = 32'hA0;
        instr1 = C_WRITE; addr1 = 24'h00000B; val1 = 32'hB0;
        model_step();
        repeat (12) begin tick(); model_step(); end
        drain();

        // READ with request dropped during ISSUE
        tick(); req = 2'b01; instr0 = C_READ; addr0 = 24'h000005; model_step();
        tick(); req = 2'b00; model_step();
        drain();

        // reset during WAIT with requester 1 holding its request
        tick(); req = 2'b10; instr1 = C_READ; addr1 = 24'h000007; model_step();
        tick(); model_step();
        do_reset(2);
        drain();

        // instruction changed right after grant
        tick(); req = 2'b01; instr0 = C_WRITE; addr0 = 24'h000020; val0 = 32'h55; model_step();
        tick(); instr0 = 8'hFF; model_step();
        tick(); model_step();
        drain();

        // randomized traffic with occasional resets
        rst_hold = 0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                model_reset(cyc);
                rst_hold = $urandom_range(1, 3);
            end
            req    = 2'($urandom_range(0, 3));
            instr0 = rand_instr();
            instr1 = rand_instr();
            addr0  = 24'($urandom);
            addr1  = 24'($urandom);
            val0   = $urandom;
            val1   = $urandom;
            model_step();
        end
        if (!rst_n) begin
            tick(); rst_n = 1'b1; req = 2'b00; model_step();
        end
        drain();
        repeat (3) begin tick(); req = 2'b00; model_step(); end

        while (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("sb_unserved", 32'h0, 32'(mon_e.ack));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
